// File: rtl/sync_pulse_shaper_if.sv
// Handshake bundle between the upstream position counter and the sync pulse shaper.
// The master drives the tick and event inputs; the slave (the shaper) drives the timing outputs.
interface sync_pulse_shaper_if;
    logic counter_enable;
    logic zero_detected;
    logic threshold_detected;
    logic display_enable;
    logic sync_out;
    logic line_done;
    logic sync_error;

    modport master (
        output counter_enable, zero_detected, threshold_detected,
        input  display_enable, sync_out, line_done, sync_error
    );

    modport slave (
        input  counter_enable, zero_detected, threshold_detected,
        output display_enable, sync_out, line_done, sync_error
    );
endinterface

// File: rtl/sync_pulse_shaper.sv
// Line timing generator: visible area, front porch, sync pulse and back porch, all counted in
// enabled ticks. Protocol violations from the upstream counter set a sticky error flag.
//
//  state          | meaning
//  ---------------+-------------------------------------------------------------
//  ST_IDLE        | after reset, waiting for the first line start
//  ST_ACTIVE      | visible pixels, display_enable high
//  ST_FRONT_PORCH | counting FRONT_PORCH ticks after the threshold event
//  ST_SYNC        | sync pulse asserted for SYNC_WIDTH ticks
//  ST_BACK_PORCH  | waiting for the next line start
module sync_pulse_shaper #(
    parameter int   FRONT_PORCH       = 16,
    parameter int   SYNC_WIDTH        = 96,
    parameter logic SYNC_ACTIVE_LEVEL = 1'b0,
    parameter int   COUNT_SIZE        = 11
) (
    input  logic                  control_clock,
    input  logic                  control_reset_n,
    sync_pulse_shaper_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FRONT_PORCH,
        ST_SYNC,
        ST_BACK_PORCH
    } state_t;

    localparam logic [COUNT_SIZE-1:0] L_ONE      = COUNT_SIZE'(1);
    localparam logic [COUNT_SIZE-1:0] L_FP_LOAD  = COUNT_SIZE'(FRONT_PORCH - 1);
    localparam logic [COUNT_SIZE-1:0] L_SW_LOAD  = COUNT_SIZE'(SYNC_WIDTH - 1);

    state_t                  r_state;
    logic [COUNT_SIZE-1:0]   r_count;
    logic                    r_display_enable;
    logic                    r_sync_out;
    logic                    r_line_done;
    logic                    r_sync_error;

    state_t                  w_state_next;
    logic [COUNT_SIZE-1:0]   w_count_next;
    logic                    w_line_done_next;
    logic                    w_sync_error_next;

    always_ff @(posedge control_clock or negedge control_reset_n) begin
        if (!control_reset_n) begin
            r_state          <= ST_IDLE;
            r_count          <= '0;
            r_display_enable <= 1'b0;
            r_sync_out       <= ~SYNC_ACTIVE_LEVEL;
            r_line_done      <= 1'b0;
            r_sync_error     <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_count          <= w_count_next;
            r_display_enable <= (w_state_next == ST_ACTIVE);
            r_sync_out       <= (w_state_next == ST_SYNC) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            r_line_done      <= w_line_done_next;
            r_sync_error     <= w_sync_error_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_line_done_next  = 1'b0;
        w_sync_error_next = r_sync_error;

        if (bus.counter_enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.zero_detected) begin
                        w_state_next     = ST_ACTIVE;
                        w_line_done_next = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // A line start here also wins over a coincident threshold.
                    if (bus.zero_detected) begin
                        w_sync_error_next = 1'b1;
                        w_line_done_next  = 1'b1;
                    end else if (bus.threshold_detected) begin
                        w_state_next = ST_FRONT_PORCH;
                        w_count_next = L_FP_LOAD;
                    end
                end
                ST_FRONT_PORCH, ST_SYNC: begin
                    if (bus.zero_detected) begin
                        w_state_next      = ST_ACTIVE;
                        w_count_next      = '0;
                        w_sync_error_next = 1'b1;
                        w_line_done_next  = 1'b1;
                    end else begin
                        // A stray threshold is flagged but the porch/pulse timing keeps running.
                        if (bus.threshold_detected) begin
                            w_sync_error_next = 1'b1;
                        end
                        if (r_count == '0) begin
                            w_state_next = (r_state == ST_FRONT_PORCH) ? ST_SYNC : ST_BACK_PORCH;
                            w_count_next = (r_state == ST_FRONT_PORCH) ? L_SW_LOAD : '0;
                        end else begin
                            w_count_next = r_count - L_ONE;
                        end
                    end
                end
                ST_BACK_PORCH: begin
                    if (bus.zero_detected) begin
                        w_state_next     = ST_ACTIVE;
                        w_line_done_next = 1'b1;
                    end else if (bus.threshold_detected) begin
                        w_sync_error_next = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    assign bus.display_enable = r_display_enable;
    assign bus.sync_out       = r_sync_out;
    assign bus.line_done      = r_line_done;
    assign bus.sync_error     = r_sync_error;

endmodule

// File: tb/tb_sync_pulse_shaper.sv
// Bench for sync_pulse_shaper: default-timing instance plus a FRONT_PORCH=1/SYNC_WIDTH=1 instance
// with an active-high sync level; expected outputs are derived from each line's event tick times.
module tb_sync_pulse_shaper;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sync_pulse_shaper_if bus0 ();
    sync_pulse_shaper_if bus1 ();

    sync_pulse_shaper dut0 (
        .control_clock   (clk),
        .control_reset_n (rst_n),
        .bus             (bus0)
    );

    sync_pulse_shaper #(
        .FRONT_PORCH       (1),
        .SYNC_WIDTH        (1),
        .SYNC_ACTIVE_LEVEL (1'b1),
        .COUNT_SIZE        (11)
    ) dut1 (
        .control_clock   (clk),
        .control_reset_n (rst_n),
        .bus             (bus1)
    );

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (de,sync,ld,err)", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int sel);
        if (sel == 0)
            return {bus0.display_enable, bus0.sync_out, bus0.line_done, bus0.sync_error};
        return {bus1.display_enable, bus1.sync_out, bus1.line_done, bus1.sync_error};
    endfunction

    task automatic drive(input int sel, input bit en, input bit z, input bit th);
        if (sel == 0) begin
            bus0.counter_enable     = en;
            bus0.zero_detected      = z;
            bus0.threshold_detected = th;
        end else begin
            bus1.counter_enable     = en;
            bus1.zero_detected      = z;
            bus1.threshold_detected = th;
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, compare just after the edge.
    task automatic step(input string tag, input int sel, input bit en, input bit z, input bit th,
                        input logic [3:0] exp);
        sb_t e;
        @(negedge clk);
        drive(sel, en, z, th);
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.tag, {28'd0, outs(e.sel)}, {28'd0, e.exp});
    endtask

    // Outputs after the edge sampling tick t of a line whose zero was tick 0.
    function automatic logic [3:0] line_exp(input int t, input int th_t, input int th2_t,
                                            input int fp, input int sw, input bit lvl,
                                            input bit err_in);
        logic de, sy, ld, er;
        de = (t < th_t);
        sy = (t >= th_t + fp && t < th_t + fp + sw) ? lvl : ~lvl;
        ld = (t == 0);
        er = err_in | (th2_t != 0 && t >= th2_t);
        return {de, sy, ld, er};
    endfunction

    // Runs enabled ticks 1..stop_t of a line already started; zero at zero_t starts the next one.
    task automatic run_line(input string tag, input int sel, input int th_t, input int th2_t,
                            input int zero_t, input int stop_t, input int fp, input int sw,
                            input bit lvl, input bit gap, input bit err_in);
        logic [3:0] ex;
        bit z, th;
        for (int t = 1; t <= stop_t; t++) begin
            z  = (t == zero_t);
            th = (t == th_t) || (t == th2_t);
            if (gap) begin
                ex    = line_exp(t - 1, th_t, th2_t, fp, sw, lvl, err_in);
                ex[1] = 1'b0;
                step({tag, "_gap"}, sel, 1'b0, z, th, ex);
            end
            if (z)
                ex = {1'b1, ~lvl, 1'b1,
                      err_in | (th2_t != 0 && th2_t <= t) | (zero_t < th_t + fp + sw)};
            else
                ex = line_exp(t, th_t, th2_t, fp, sw, lvl, err_in);
            step(tag, sel, 1'b1, z, th, ex);
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut0", {28'd0, outs(0)}, 32'h4);
        check("reset_dut1", {28'd0, outs(1)}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) step("idle_thr_ignored", 0, 1'b1, 1'b0, 1'b1, 4'b0100);
        step("first_zero", 0, 1'b1, 1'b1, 1'b0, 4'b1110);
        run_line("nominal", 0, 1072, 0, 1328, 1328, 16, 96, 1'b0, 1'b0, 1'b0);
        run_line("gapped", 0, 1072, 0, 1328, 1328, 16, 96, 1'b0, 1'b1, 1'b0);
        run_line("zero_thr_same", 0, 5, 0, 5, 5, 16, 96, 1'b0, 1'b0, 1'b0);
        run_line("err_sticky", 0, 1072, 0, 1328, 1328, 16, 96, 1'b0, 1'b0, 1'b1);
        run_line("pre_reset", 0, 1072, 0, 2000, 1100, 16, 96, 1'b0, 1'b0, 1'b1);

        @(posedge clk);
        #2;
        check("in_sync_before_rst", {28'd0, outs(0)}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("async_reset", {28'd0, outs(0)}, 32'h4);
        #1;
        rst_n = 1'b1;

        repeat (4) step("post_reset_idle", 0, 1'b1, 1'b0, 1'b1, 4'b0100);
        step("resync_zero", 0, 1'b1, 1'b1, 1'b0, 4'b1110);
        run_line("early_zero_sync", 0, 1072, 0, 1128, 1128, 16, 96, 1'b0, 1'b0, 1'b0);
        run_line("err_hold", 0, 1072, 0, 1328, 20, 16, 96, 1'b0, 1'b0, 1'b1);

        step("b_first_zero", 1, 1'b1, 1'b1, 1'b0, 4'b1010);
        run_line("boundary", 1, 3, 0, 8, 8, 1, 1, 1'b1, 1'b0, 1'b0);
        run_line("bp_thr_err", 1, 3, 6, 8, 8, 1, 1, 1'b1, 1'b0, 1'b0);
        run_line("b_gapped", 1, 3, 0, 8, 8, 1, 1, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_pulse_shaper.md
SYNC_PULSE_SHAPER -- requirements
Module: Sync_Pulse_Shaper

Interface
REQ-001 Parameter FRONT_PORCH, default 16: enabled ticks from threshold event to sync assertion; legal range 1..2047.
REQ-002 Parameter SYNC_WIDTH, default 96: sync pulse length in enabled ticks; legal range 1..2047.
REQ-003 Parameter SYNC_ACTIVE_LEVEL, default 1'b0: level of sync_out while the pulse is asserted.
REQ-004 Parameter COUNT_SIZE, default 11: width of the internal down-counter.
REQ-005 control_clock  input  1  single clock; all state updates on its rising edge.
REQ-006 control_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 counter_enable  input  1  pixel tick; this block samples the event inputs and advances state only when it is 1.
REQ-008 zero_detected  input  1  line-start event from the upstream position counter, when its count equals 0.
REQ-009 threshold_detected  input  1  end-of-visible-area event from the upstream position counter.
REQ-010 display_enable  output  1  registered; 1 while pixels are visible.
REQ-011 sync_out  output  1  registered sync pulse at SYNC_ACTIVE_LEVEL.
REQ-012 line_done  output  1  registered one-cycle strobe per accepted line start; drives the next axis counter's counter_enable.
REQ-013 sync_error  output  1  registered sticky protocol-violation flag.

Function
REQ-014 The FSM SHALL have the states IDLE, ACTIVE, FRONT_PORCH, SYNC and BACK_PORCH, and SHALL hold in every state when counter_enable=0.
REQ-015 All transitions listed below SHALL occur only on a control_clock edge where counter_enable=1.
REQ-016 IDLE: zero_detected=1 SHALL move the FSM to ACTIVE and pulse line_done; all other inputs SHALL be ignored, with no error.
REQ-017 ACTIVE: threshold_detected=1 SHALL move the FSM to FRONT_PORCH and load the down-counter with FRONT_PORCH-1.
REQ-018 FRONT_PORCH: the down-counter SHALL decrement by 1 per tick; at 0 the FSM SHALL move to SYNC and load SYNC_WIDTH-1.
REQ-019 SYNC: the down-counter SHALL decrement by 1 per tick; at 0 the FSM SHALL move to BACK_PORCH.
REQ-020 BACK_PORCH: zero_detected=1 SHALL move the FSM to ACTIVE and pulse line_done.
REQ-021 display_enable SHALL equal 1 exactly when the registered state is ACTIVE.
REQ-022 sync_out SHALL equal SYNC_ACTIVE_LEVEL exactly when the state is SYNC, and its inverse otherwise.
REQ-023 Latency: every output SHALL change on the same edge as the state change that causes it (one edge after the enabled tick on which the event is sampled).
REQ-024 Pulse widths: display_enable SHALL stay low for exactly FRONT_PORCH enabled ticks before sync_out asserts, and sync_out SHALL stay asserted for exactly SYNC_WIDTH enabled ticks.
REQ-025 line_done SHALL be high for exactly one control_clock cycle per accepted zero_detected, even if counter_enable stays 1.
REQ-026 zero_detected in ACTIVE, FRONT_PORCH or SYNC SHALL set sync_error, force the FSM to ACTIVE (resynchronise) and pulse line_done.
REQ-027 threshold_detected in FRONT_PORCH, SYNC or BACK_PORCH SHALL set sync_error and SHALL NOT change the state.
REQ-028 If zero_detected and threshold_detected are both 1 on one enabled tick, zero_detected SHALL take priority; outside IDLE, sync_error SHALL also be set.
REQ-029 The down-counter SHALL never wrap below 0; a value of 0 always causes the state exit.
REQ-030 sync_error, once set, SHALL remain 1 until reset.

Reset
REQ-031 While control_reset_n=0, regardless of clock: state=IDLE, down-counter=0, display_enable=0, sync_out=~SYNC_ACTIVE_LEVEL, line_done=0, sync_error=0.
REQ-032 Reset asserted mid-pulse SHALL deassert sync_out immediately, and no line_done SHALL be emitted.
REQ-033 After reset release, the block SHALL output no display_enable until the first zero_detected.

Verification
REQ-034 Nominal line: enable always 1, zero at t=0, threshold at t=1072, zero at t=1328 -> display_enable high for 1072 ticks; sync_out low from tick 1088 for 96 ticks; one line_done at each zero; sync_error=0.
REQ-035 Gapped enable: counter_enable=1 every 2nd cycle, same events -> identical tick counts; line_done still exactly one cycle wide.
REQ-036 Early zero during SYNC (40 ticks in) -> sync_out deasserts, display_enable=1 on the next edge, line_done pulses, sync_error=1 and stays 1.
REQ-037 zero and threshold on the same tick while in ACTIVE -> state stays ACTIVE, line_done pulses, sync_error=1.
REQ-038 control_reset_n pulled low for 3 ns between clock edges during SYNC -> outputs reach their reset values asynchronously; after release, display_enable stays 0 until the first zero_detected.
REQ-039 Boundary case FRONT_PORCH=1, SYNC_WIDTH=1 -> sync_out asserts for exactly one enabled tick, exactly one tick after threshold.
